// File: rtl/write_pointer_full_if.sv
// Write-side bundle of the async FIFO write-pointer stage: producer request,
// synchronized read pointer, and the status/memory outputs.
interface write_pointer_full_if #(
  parameter int unsigned address_size = 3
);
  logic                    write_enable_i;
  logic [address_size:0]   read_to_write_pointer_i;
  logic                    clear_overflow_i;
  logic [address_size-1:0] write_address_o;
  logic                    mem_write_enable_o;
  logic [address_size:0]   write_pointer_o;
  logic                    full_o;
  logic                    almost_full_o;
  logic [address_size:0]   write_level_o;
  logic                    overflow_o;

  // Producer / environment side.
  modport master (
    output write_enable_i,
    output read_to_write_pointer_i,
    output clear_overflow_i,
    input  write_address_o,
    input  mem_write_enable_o,
    input  write_pointer_o,
    input  full_o,
    input  almost_full_o,
    input  write_level_o,
    input  overflow_o
  );

  // Write-pointer block side.
  modport slave (
    input  write_enable_i,
    input  read_to_write_pointer_i,
    input  clear_overflow_i,
    output write_address_o,
    output mem_write_enable_o,
    output write_pointer_o,
    output full_o,
    output almost_full_o,
    output write_level_o,
    output overflow_o
  );
endinterface

// File: rtl/write_pointer_full.sv
// Write-domain control of the async FIFO: binary/Gray write pointer, write
// qualification, registered full / almost-full / level, sticky overflow.
module write_pointer_full #(
  parameter int unsigned address_size          = 3,
  parameter int unsigned almost_full_threshold = 6
) (
  input logic                  write_clk_i,
  input logic                  write_reset_i,
  write_pointer_full_if.slave  bus
);
  localparam int unsigned PtrW = address_size + 1;

  logic [PtrW-1:0] bin_q, bin_d;
  logic [PtrW-1:0] gray_q, gray_d;
  logic [PtrW-1:0] level_q, level_d;
  logic            full_q, full_d;
  logic            almost_full_q, almost_full_d;
  logic            overflow_q, overflow_d;
  logic            accept;
  logic [PtrW-1:0] rg;
  logic [PtrW-1:0] rbin;
  logic [PtrW-1:0] full_gray;

  assign rg = bus.read_to_write_pointer_i;

  // Next-state pointer, level and flags; read-pointer movement and a write
  // accept in the same cycle are both folded in, so full never glitches.
  always_comb begin
    accept    = bus.write_enable_i & ~full_q;
    bin_d     = bin_q + PtrW'(accept);
    gray_d    = bin_d ^ (bin_d >> 1);
    rbin      = '0;
    for (int i = 0; i < int'(PtrW); i++) begin
      rbin[i] = ^(rg >> i);
    end
    // Gray of (read pointer + depth): top two bits inverted.
    full_gray = {~rg[PtrW-1:PtrW-2], rg[PtrW-3:0]};
    full_d        = (gray_d == full_gray);
    level_d       = bin_d - rbin;
    almost_full_d = (level_d >= PtrW'(almost_full_threshold));
    overflow_d    = overflow_q;
    if (bus.write_enable_i && full_q) begin
      overflow_d = 1'b1;
    end else if (bus.clear_overflow_i) begin
      overflow_d = 1'b0;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge write_clk_i or posedge write_reset_i) begin
    if (write_reset_i) begin
      bin_q         <= '0;
      gray_q        <= '0;
      level_q       <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      bin_q         <= bin_d;
      gray_q        <= gray_d;
      level_q       <= level_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  assign bus.write_address_o    = bin_q[address_size-1:0];
  assign bus.mem_write_enable_o = bus.write_enable_i & ~full_q;
  assign bus.write_pointer_o    = gray_q;
  assign bus.full_o             = full_q;
  assign bus.almost_full_o      = almost_full_q;
  assign bus.write_level_o      = level_q;
  assign bus.overflow_o         = overflow_q;
endmodule

// File: tb/tb_write_pointer_full.sv
// Self-checking bench for write_pointer_full (address_size=3, threshold=6).
// Reference model tracks write/read counts as integers and derives flags.
module tb_write_pointer_full;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int MODV  = 16;
  localparam int AFT   = 6;

  logic write_clk_i;
  logic write_reset_i;
  write_pointer_full_if #(.address_size(AW)) bus ();

  write_pointer_full #(
    .address_size          (AW),
    .almost_full_threshold (AFT)
  ) dut (
    .write_clk_i   (write_clk_i),
    .write_reset_i (write_reset_i),
    .bus           (bus)
  );

  initial write_clk_i = 1'b0;
  always #5 write_clk_i = ~write_clk_i;

  int n_vec;
  int n_err;

  // Reference state: counts as plain integers.
  int m_wr;
  int m_rd;
  int m_level;
  bit m_full;
  bit m_af;
  bit m_ovf;

  function automatic int gray(input int b);
    return (b ^ (b >> 1)) & (MODV - 1);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".addr"},  int'(bus.write_address_o), m_wr % DEPTH);
    check({tag, ".gray"},  int'(bus.write_pointer_o), gray(m_wr));
    check({tag, ".full"},  int'(bus.full_o), int'(m_full));
    check({tag, ".afull"}, int'(bus.almost_full_o), int'(m_af));
    check({tag, ".level"}, int'(bus.write_level_o), m_level);
    check({tag, ".ovf"},   int'(bus.overflow_o), int'(m_ovf));
  endtask

  // One clock: drive at negedge, check strobe, clock, update model, check.
  task automatic step(input bit we, input int rd_new, input bit clr, input string tag);
    bit acc;
    @(negedge write_clk_i);
    bus.write_enable_i          = we;
    bus.read_to_write_pointer_i = 4'(gray(rd_new));
    bus.clear_overflow_i        = clr;
    #1;
    acc = we && !m_full;
    check({tag, ".mwe"}, int'(bus.mem_write_enable_o), int'(acc));
    @(posedge write_clk_i);
    if (we && m_full) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_wr    = (m_wr + int'(acc)) % MODV;
    m_rd    = rd_new % MODV;
    m_level = (m_wr - m_rd + MODV) % MODV;
    m_full  = (m_level == DEPTH);
    m_af    = (m_level >= AFT);
    #1;
    check_regs(tag);
  endtask

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0;
  endtask

  int prev_gray;
  int diff;

  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();
    bus.write_enable_i          = 1'b0;
    bus.read_to_write_pointer_i = '0;
    bus.clear_overflow_i        = 1'b0;
    write_reset_i               = 1'b1;
    repeat (2) @(posedge write_clk_i);
    #1;
    check_regs("rst");
    @(negedge write_clk_i);
    write_reset_i = 1'b0;

    // Idle after reset.
    step(0, 0, 0, "idle");
    step(0, 0, 0, "idle");

    // Fill to full with read pointer held at 0.
    for (int i = 0; i < 8; i++) step(1, 0, 0, "fill");
    check("fill_gray12", int'(bus.write_pointer_o), 12);

    // Dropped writes while full, then overflow clear priority.
    step(1, 0, 0, "drop");
    step(1, 0, 0, "drop");
    step(0, 0, 0, "hold");
    step(0, 0, 1, "clr");
    step(1, 0, 1, "clr_set");

    // Read pointer jumps to 3: full releases, level 5.
    step(0, 3, 0, "rdadv");
    for (int i = 0; i < 3; i++) step(1, 3, 0, "wrap");
    check("wrap_bin11", int'(bus.write_pointer_o), gray(11));

    // Read pointer trails by 2; Gray changes one bit per accept.
    step(0, (m_wr + MODV - 2) % MODV, 0, "trail0");
    for (int i = 0; i < 40; i++) begin
      prev_gray = int'(bus.write_pointer_o);
      step(1, (m_wr + MODV - 1) % MODV, 0, "trail");
      diff = $countones(prev_gray ^ int'(bus.write_pointer_o));
      check("gray1bit", diff, 1);
    end

    // Build level 7, then write and read advance together.
    for (int i = 0; i < 5; i++) step(1, m_rd, 0, "lvl7");
    step(1, (m_rd + 1) % MODV, 0, "same");
    check("same_level7", int'(bus.write_level_o), 7);

    // Random traffic; read pointer only advances over written entries.
    for (int i = 0; i < 400; i++) begin
      int rd_n;
      rd_n = m_rd;
      if (m_level > 0 && ($urandom_range(0, 99) < 45)) rd_n = (m_rd + 1) % MODV;
      step(bit'($urandom_range(0, 99) < 60), rd_n, bit'($urandom_range(0, 9) == 0), "rand");
    end

    // Asynchronous reset mid-burst, away from any clock edge.
    @(negedge write_clk_i);
    bus.write_enable_i = 1'b1;
    #2;
    write_reset_i = 1'b1;
    #1;
    model_reset();
    check_regs("arst");
    @(negedge write_clk_i);
    bus.write_enable_i          = 1'b0;
    bus.read_to_write_pointer_i = '0;
    write_reset_i               = 1'b0;
    step(1, 0, 0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/write_pointer_full.md
Name: write_pointer_full

Overview:
- Write-domain control stage of the asynchronous FIFO; sits directly downstream of the read-to-write pointer synchronizer.
- Owns the write pointer in binary and Gray form and qualifies write requests.
- Generates the memory write strobe and address.
- Compares its own pointer against the synchronized Gray read pointer to produce full, almost-full, fill level and a sticky overflow error.

Parameters:
- address_size, 3, memory address width; FIFO depth = 2^address_size; legal range is 2 or more.
- almost_full_threshold, 6, fill level at or above which almost_full_o asserts; legal range 1 to 2^address_size.

Ports:
- write_clk_i  input  1  write-domain clock; all state updates on its rising edge.
- write_reset_i  input  1  asynchronous, active-high reset.
- write_enable_i  input  1  write request from the producer.
- read_to_write_pointer_i  input  address_size+1  Gray-coded read pointer, already synchronized into the write domain.
- clear_overflow_i  input  1  clears the sticky overflow flag.
- write_address_o  output  address_size  memory write address; equals the binary write pointer's low address_size bits.
- mem_write_enable_o  output  1  memory write strobe; equals write_enable_i AND NOT full_o (combinational).
- write_pointer_o  output  address_size+1  registered Gray write pointer, sent to the write-to-read synchronizer.
- full_o  output  1  registered full flag.
- almost_full_o  output  1  registered almost-full flag.
- write_level_o  output  address_size+1  registered fill level as seen from the write domain (0 to depth).
- overflow_o  output  1  sticky overflow error flag.

Behaviour:
- Reset (asynchronous, while write_reset_i=1): binary pointer=0, write_pointer_o=0, full_o=0, almost_full_o=0, write_level_o=0, overflow_o=0. Release takes effect on the next clock edge; no pending state survives a mid-operation reset.
- Accept: a write is accepted when write_enable_i=1 and full_o=0.
  - mem_write_enable_o=1 in the same cycle; data is written at the current write_address_o.
  - The binary pointer increments on that edge.
  - Requests while full_o=1 are dropped: pointer unchanged, no strobe.
- Next-pointer arithmetic:
  - next_bin = bin + accept, modulo 2^(address_size+1); the extra MSB is the wrap bit.
  - next_gray = next_bin XOR (next_bin >> 1).
  - write_pointer_o <= next_gray each cycle, so it changes by at most one bit per cycle.
- Full detection (registered, zero extra latency versus the pointer):
  - full_o <= (next_gray == {~rg[address_size:address_size-1], rg[address_size-2:0]}), where rg = read_to_write_pointer_i.
  - full_o asserts on the same edge that accepts the depth-th outstanding write.
  - full_o deasserts only on the first edge after the synchronized read pointer advances. This is pessimistic by the synchronizer latency, which is intended.
- Level:
  - Convert rg to binary rbin (prefix XOR from MSB down).
  - write_level_o <= next_bin - rbin, modulo 2^(address_size+1); value is always in 0..depth.
- Almost full: almost_full_o <= (next_bin - rbin) >= almost_full_threshold. It is computed from the same next-state level, so it stays consistent with write_level_o in every cycle.
- Overflow:
  - Set when write_enable_i=1 and full_o=1 (a dropped write).
  - Cleared when clear_overflow_i=1.
  - If both occur in the same cycle, set wins. The flag holds otherwise.
- Wrap-around: the pointer rolls from 2^(address_size+1)-1 to 0 with no special handling. Gray code stays single-bit-change across the wrap.
- Simultaneous accept and read-pointer movement: both are folded into next-state full, level and almost-full. No transient false full.
- read_to_write_pointer_i is treated as stable synchronized data; no additional synchronization inside this block.

Test Plan (address_size=3, depth 8, almost_full_threshold=6):
- Reset then idle with rg=0 -> all outputs 0; mem_write_enable_o=0. Assert write_reset_i asynchronously mid-burst -> outputs clear immediately, without waiting for a clock.
- 8 consecutive writes, rg held 0 -> write_address_o 0..7; write_pointer_o Gray 1,3,2,6,7,5,4,12. almost_full_o=1 after the 6th write; full_o=1 after the 8th write; write_level_o=8.
- While full, pulse write_enable_i for 2 cycles -> mem_write_enable_o=0, pointer stays 12 (Gray), overflow_o=1 and stays 1. Next, clear_overflow_i alone -> overflow_o=0. Next, clear_overflow_i together with a dropped write -> overflow_o=1.
- From full, drive rg to Gray of binary 3 (value 2) -> next edge: full_o=0, write_level_o=5, almost_full_o=0. Then 3 writes -> full_o=1, with binary pointer 11 and address wrapping 7->0->1->2.
- Run 40 writes with rg tracking pointer minus 2 (Gray) -> no full_o, write_level_o=2 steady; Gray pointer changes exactly one bit per accept, including at the wrap 15->0.
- Same-cycle write accept and rg advance at level 7 -> full_o stays 0, write_level_o stays 7.
